// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults, the NONE register ID and the dump FSM state type
package regfile_pkg;
  localparam int DATA_W_DEF = 64;
  localparam int ID_W_DEF = 4;
  localparam int NREG_DEF = 15;
  localparam logic [ID_W_DEF-1:0] NONE_ID = '1;
  typedef enum logic {DUMP_IDLE, DUMP_RUN} dump_state_t;
endpackage

// File: rtl/regfile_dump_seq.sv
// regfile_dump_seq: streams r[0..NREG-1] out one register per cycle for the debug path
module regfile_dump_seq
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              dump_req,
  output logic [ID_W-1:0]   rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ID_W-1:0]   dump_idx,
  output logic [DATA_W-1:0] dump_data
);
  localparam logic [ID_W-1:0] LAST = ID_W'(NREG - 1);
  dump_state_t state, state_n;
  logic advance;
  // dump_idx doubles as the counter; rd_idx looks one beat ahead so data is registered with it
  always_comb begin
    rd_idx = state == DUMP_RUN ? dump_idx + 1'b1 : '0;
    advance = state == DUMP_RUN ? dump_idx != LAST : dump_req;
    state_n = advance ? DUMP_RUN : DUMP_IDLE;
  end
  always_ff @(posedge clock)
    if (reset) begin
      state <= DUMP_IDLE;
      dump_valid <= 1'b0;
      dump_idx <= '0;
      dump_data <= '0;
    end else begin
      state <= state_n;
      dump_valid <= advance;
      if (advance) begin
        dump_idx <= rd_idx;
        dump_data <= rd_data;
      end
    end
  assign dump_busy = state == DUMP_RUN;
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: two-write/two-read register file with read hold and a sequential dump port
// REGFILE_BYPASS_EN: reads at the edge of a write return the new data (E over M)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG = NREG_DEF,
  parameter int ID_W = ID_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ID_W-1:0]   dst_m,
  input  logic [DATA_W-1:0] val_m,
  input  logic [ID_W-1:0]   dst_e,
  input  logic [DATA_W-1:0] val_e,
  input  logic [ID_W-1:0]   src_a,
  input  logic [ID_W-1:0]   src_b,
  input  logic              stall,
  output logic [DATA_W-1:0] val_a,
  output logic [DATA_W-1:0] val_b,
  input  logic              dump_req,
  output logic              dump_busy,
  output logic              dump_valid,
  output logic [ID_W-1:0]   dump_idx,
  output logic [DATA_W-1:0] dump_data
);
  localparam logic [ID_W-1:0] NONE = '1;
  localparam logic [ID_W-1:0] NREG_ID = ID_W'(NREG);
  logic [DATA_W-1:0] r [NREG];
  logic [DATA_W-1:0] rd_a, rd_b, dump_rd_data;
  logic [ID_W-1:0] dump_rd_idx;
  function automatic logic [DATA_W-1:0] read_port(input logic [ID_W-1:0] src);
`ifdef REGFILE_BYPASS_EN
    return src >= NREG_ID ? '0 : dst_e == src ? val_e : dst_m == src ? val_m : r[src];
`else
    return src >= NREG_ID ? '0 : r[src];
`endif
  endfunction
  always_comb begin
    rd_a = read_port(src_a);
    rd_b = read_port(src_b);
    dump_rd_data = dump_rd_idx < NREG_ID ? r[dump_rd_idx] : '0;
  end
  // NONE is never below NREG, so an index match alone implies a valid write
  always_ff @(posedge clock)
    for (int i = 0; i < NREG; i++)
      if (reset) r[i] <= '0;
      else if (dst_e == ID_W'(i)) r[i] <= val_e;
      else if (dst_m == ID_W'(i)) r[i] <= val_m;
  always_ff @(posedge clock)
    if (reset) begin
      val_a <= '0;
      val_b <= '0;
    end else if (!stall) begin
      if (src_a != NONE) val_a <= rd_a;
      if (src_b != NONE) val_b <= rd_b;
    end
  regfile_dump_seq #(.DATA_W(DATA_W), .NREG(NREG), .ID_W(ID_W)) u_dump (
    .clock(clock),
    .reset(reset),
    .dump_req(dump_req),
    .rd_idx(dump_rd_idx),
    .rd_data(dump_rd_data),
    .dump_busy(dump_busy),
    .dump_valid(dump_valid),
    .dump_idx(dump_idx),
    .dump_data(dump_data)
  );
endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised two-write/two-read register file for the Y86-style CPU datapath, the successor to the fixed 15×64 register file. It sits between decode and write-back: write-back drives the M and E write ports, and decode reads the A and B operands. Over the previous file it adds:
- synchronous reset;
- defined out-of-range handling;
- a read-hold stall input;
- a sequential dump engine that streams every register out, one per cycle, for the debug UART path.

## Interface
Parameters:
- DATA_W, default 64: register width in bits.
- NREG, default 15: number of architectural registers. Must satisfy NREG ≤ 2^ID_W − 1.
- ID_W, default 4: width of register identifiers. The all-ones ID is NONE.

Ports:
- clock  in  1  single clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- dst_m  in  ID_W  M write destination; NONE means no write.
- val_m  in  DATA_W  M write data.
- dst_e  in  ID_W  E write destination; NONE means no write.
- val_e  in  DATA_W  E write data.
- src_a  in  ID_W  A read source; NONE means hold.
- src_b  in  ID_W  B read source; NONE means hold.
- stall  in  1  freezes val_a and val_b; writes still proceed.
- val_a  out  DATA_W  registered A operand.
- val_b  out  DATA_W  registered B operand.
- dump_req  in  1  pulse to start a dump; ignored while busy.
- dump_busy  out  1  dump in progress.
- dump_valid  out  1  dump_idx and dump_data are valid this cycle.
- dump_idx  out  ID_W  index of the register being dumped.
- dump_data  out  DATA_W  contents of register dump_idx.

## Operation
- Storage: NREG × DATA_W flops, r[0..NREG−1].

Reset (any cycle, including mid-dump):
- All r[i] are cleared to 0.
- val_a and val_b are cleared to 0.
- The dump FSM goes to IDLE, and dump_busy, dump_valid, dump_idx and dump_data are cleared to 0.
- Writes and reads presented in a reset cycle are discarded.

Writes:
- The M port writes when dst_m ≠ NONE and dst_m < NREG.
- The E port writes under the same rule, using dst_e.
- When dst_m == dst_e and both are valid, E wins and the M data is lost.
- An ID ≥ NREG that is not NONE is ignored: no write, no error.

Reads:
- When stall = 0 and src_x ≠ NONE, val_x loads the register value at the edge.
- src_x ≥ NREG (and not NONE) loads 0.
- src_x == NONE, or stall = 1, holds val_x.
- Same-cycle write/read hazard behaviour is governed by REGFILE_BYPASS_EN (see Configuration).

Dump FSM, states IDLE and DUMP:
- IDLE: dump_req = 1 moves to DUMP with the index counter at 0.
- DUMP, each cycle:
  - dump_valid = 1;
  - dump_idx = counter;
  - dump_data = r[counter] as it stood before that edge's writes.
- The counter increments each cycle. After it presents NREG−1, the FSM returns to IDLE.
- dump_busy is high for exactly NREG cycles.
- The register ports are fully functional during a dump, and the dump does not stall the datapath.

## Timing
- Write latency: 1 cycle. A value written at edge k is readable through a read sampled at edge k+1.
- Read latency: 1 cycle, registered at the edge where src is sampled.
- Dump: the first dump_valid appears in the cycle after the edge where dump_req is sampled. There are NREG consecutive valid beats with no gaps.
- A new dump_req is accepted in the first IDLE cycle after a dump completes.

## Configuration
- Macro: REGFILE_BYPASS_EN.

Defined (write-first, matching legacy behaviour):
- A read at edge k of a register written at edge k returns the new data.
- When both M and E write that register, the read returns the E data.

Undefined (read-first):
- The same read returns the pre-write value.
- This mode saves the forwarding muxes; hazards are then covered by the pipeline forwarding unit.

## Structure
- Package regfile_pkg contains:
  - default DATA_W, ID_W and NREG constants;
  - the NONE_ID constant (all ones of ID_W);
  - the dump-state enum {DUMP_IDLE, DUMP_RUN}.
- Sub-module regfile_dump_seq contains the FSM, the index counter and the dump_* output registers. It reads the register array through a read-only index/data interface.
- The top level, regfile_mp, holds the array, the write-priority logic, the read muxes and the optional bypass.

## Test plan
- Reset and readback:
  - Stimulus: write r3 = 0x55 and assert reset, then read src_a = 3.
  - Required: val_a = 0; every output is 0 during and after reset.
- Write priority:
  - Stimulus: dst_m = dst_e = 2 with val_m = 0x11 and val_e = 0x22, then read r2.
  - Required: val_a = 0x22.
- Same-cycle hazard:
  - Stimulus: write r5 = 0xAB while src_b = 5 in the same cycle.
  - Required with REGFILE_BYPASS_EN: val_b = 0xAB.
  - Required without it: the old r5 value; the next cycle reads 0xAB.
- Hold and out-of-range:
  - Stimulus: stall = 1 with a changing src_a, then src_a = NONE, then src_a = 14 with NREG = 8, ID_W = 4.
  - Required: val_a holds through the stall and the NONE read, then reads 0.
  - Also required: a write to ID 14 changes no register.
- Full dump:
  - Stimulus: preload r[i] = i+1 and pulse dump_req.
  - Required: NREG valid beats, idx 0..NREG−1 with data 1..NREG, and dump_busy falling after the last beat.
  - Also required: a second dump_req mid-dump is ignored.
- Reset mid-dump:
  - Stimulus: assert reset at beat 4.
  - Required: next cycle dump_valid = 0, dump_busy = 0, idx = 0.
  - Also required: a following dump_req restarts at idx 0 with all data 0.
